dct_block_buffer: RTL and testbench
===================================

Name: dct_block_buffer

Overview:
Memory-side responder for the 2-D DCT core's pixel-read and coefficient-write ports. It collects one N×N block of pixels from an upstream valid/ready stream and pulses start to the DCT. It then serves the DCT's read addresses with pixel data and captures the DCT's coefficient writes. After the DCT signals done, it streams the coefficient block out in address order. It sits between the pixel source and the DCT core, replacing the external RAMs the core expects.

Parameters:
IN_W, 8, pixel width (matches DCT bpp)
OUT_W, 12, coefficient width (bpp + n/2 for forward DCT)
DEPTH, 64, entries per block (n*n)
ADDR_W, 6, address width, ceil(log2(DEPTH))

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
init_n  in  1  synchronous active-low soft clear, same effect as rst_n
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel ready
s_data  in  IN_W  input pixel
dct_start  out  1  one-cycle start pulse to DCT
dct_done  in  1  DCT block complete
dct_rd_add  in  ADDR_W  DCT pixel read address
dct_rd_data  out  IN_W  pixel at dct_rd_add, registered
dct_wr_add  in  ADDR_W  DCT coefficient write address
dct_wr_n  in  1  DCT coefficient write strobe, active low
dct_wr_data  in  OUT_W  coefficient to write
m_valid  out  1  output coefficient valid
m_ready  in  1  output coefficient ready
m_data  out  OUT_W  output coefficient
m_last  out  1  high with the final (index DEPTH-1) coefficient
busy  out  1  high whenever state is not FILL

Behaviour:
- Storage: in_mem (DEPTH×IN_W) and out_mem (DEPTH×OUT_W). Contents are not reset. Single block only, no ping-pong.
- rst_n low or init_n low, sampled at clk:
  - state=FILL, wcnt=0, rcnt=0
  - dct_start=0, m_valid=0, dct_rd_data=0, busy=0
  - s_ready=1 from the first cycle after reset deasserts
  - rst_n has priority; both behave identically.
- FILL:
  - s_ready=1.
  - On s_valid&s_ready: in_mem[wcnt]=s_data, wcnt++.
  - The accept at wcnt=DEPTH-1 moves state to START. s_ready=0 from the next cycle.
- START: dct_start=1 for exactly one cycle, then state goes to RUN.
- dct_rd_data <= in_mem[dct_rd_add] every cycle in every state (1-cycle read latency).
- RUN:
  - If dct_wr_n=0: out_mem[dct_wr_add]=dct_wr_data.
  - On dct_done=1: state goes to DRAIN. A write in the same cycle as done is captured.
- dct_wr_n=0 outside RUN: ignored, out_mem unchanged.
- dct_done outside RUN: ignored.
- DRAIN:
  - m_valid=1 from the first DRAIN cycle; m_data=out_mem[rcnt].
  - m_last = (rcnt==DEPTH-1).
  - On m_valid&m_ready: rcnt++.
  - m_data and m_last are held stable while m_valid&!m_ready.
  - Handshake with m_last moves state to FILL with wcnt=rcnt=0. m_valid=0 and s_ready=1 on the next cycle.
- Out-of-range addresses: cannot occur when DEPTH=2^ADDR_W. Otherwise, addresses >= DEPTH read 0 and writes to them are dropped.
- Reset mid-operation: abandons the block from any state. No dct_start is emitted afterwards until a full new FILL completes.
- Counters never wrap inside a block. wcnt and rcnt saturate at their terminal transitions above.

Test Plan:
1. Hold rst_n=0 for 2 cycles, then release -> s_ready=1, m_valid=0, dct_start=0, dct_rd_data=0, busy=0.
2. Stream 64 pixels with s_data=i, s_valid held high throughout -> exactly 64 accepts; s_ready=0 the cycle after the 64th; dct_start=1 for exactly one cycle; busy=1.
3. In RUN, drive dct_rd_add=5 then 63 on consecutive cycles -> dct_rd_data=5 and then 63, each one cycle after its address.
4. In RUN, write addr k with data 0xA00+k for k=0..63 in scrambled order, with the k=63 write in the same cycle as dct_done=1; issue one stray write (addr 0, data 0xFFF) after done -> drain yields 0xA00..0xA3F in order; m_last only on the 64th word; stray write absent.
5. In DRAIN, toggle m_ready 1/0 each cycle -> m_data stable during stalls; exactly 64 transfers; s_ready=1 and busy=0 the cycle after the last handshake.
6. Pulse init_n=0 for one cycle mid-RUN -> next cycle s_ready=1, busy=0, m_valid=0; a fresh 64-pixel fill produces a single new dct_start pulse.

Source files
------------

// File: rtl/dct_block_buffer.sv
// Single-block pixel/coefficient buffer between a valid/ready pixel stream and a 2-D DCT core.
// Collects DEPTH pixels, starts the DCT, serves its reads and writes, then drains coefficients in order.
module dct_block_buffer #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 12,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_data,
  output logic              dct_start,
  input  logic              dct_done,
  input  logic [ADDR_W-1:0] dct_rd_add,
  output logic [IN_W-1:0]   dct_rd_data,
  input  logic [ADDR_W-1:0] dct_wr_add,
  input  logic              dct_wr_n,
  input  logic [OUT_W-1:0]  dct_wr_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_last,
  output logic              busy
);

  typedef enum logic [1:0] {FILL, START, RUN, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   wcnt_q, rcnt_q;
  logic                s_ready_q, dct_start_q, m_valid_q, busy_q;
  logic [IN_W-1:0]     rd_data_q;

  logic [IN_W-1:0]     in_mem  [DEPTH];
  logic [OUT_W-1:0]    out_mem [DEPTH];

  logic clear, s_fire, m_fire, rd_in_range, wr_in_range;

  assign clear       = !rst_n || !init_n;
  assign s_fire      = s_valid && s_ready_q;
  assign m_fire      = m_valid_q && m_ready;
  assign rd_in_range = int'(dct_rd_add) < DEPTH;
  assign wr_in_range = int'(dct_wr_add) < DEPTH;

  // Control FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= FILL;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      s_ready_q   <= 1'b1;
      dct_start_q <= 1'b0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (s_fire) begin
            if (wcnt_q == LAST) begin
              state_q     <= START;
              s_ready_q   <= 1'b0;
              dct_start_q <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        START: begin
          dct_start_q <= 1'b0;
          state_q     <= RUN;
        end
        RUN: begin
          if (dct_done) begin
            state_q   <= DRAIN;
            m_valid_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (m_fire) begin
            if (rcnt_q == LAST) begin
              state_q   <= FILL;
              m_valid_q <= 1'b0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b0;
              wcnt_q    <= '0;
              rcnt_q    <= '0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset so they map onto plain RAM; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (!clear && state_q == FILL && s_fire)
      in_mem[wcnt_q] <= s_data;
    if (!clear && state_q == RUN && !dct_wr_n && wr_in_range)
      out_mem[dct_wr_add] <= dct_wr_data;
  end

  always_ff @(posedge clk) begin
    if (clear)
      rd_data_q <= '0;
    else
      rd_data_q <= rd_in_range ? in_mem[dct_rd_add] : '0;
  end

  assign s_ready     = s_ready_q;
  assign dct_start   = dct_start_q;
  assign dct_rd_data = rd_data_q;
  assign m_valid     = m_valid_q;
  assign m_data      = out_mem[rcnt_q];
  assign m_last      = m_valid_q && (rcnt_q == LAST);
  assign busy        = busy_q;

endmodule

// File: tb/tb_dct_block_buffer.sv
// Randomized scoreboard bench for dct_block_buffer: a monitor pops expected coefficients on every
// output handshake while the main process walks fill, read, write, drain and soft-clear scenarios.
module tb_dct_block_buffer;

  localparam int IN_W = 8, OUT_W = 12, DEPTH = 64, ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n, init_n, s_valid, s_ready, dct_start, dct_done, dct_wr_n;
  logic              m_valid, m_ready, m_last, busy;
  logic [IN_W-1:0]   s_data, dct_rd_data;
  logic [ADDR_W-1:0] dct_rd_add, dct_wr_add;
  logic [OUT_W-1:0]  dct_wr_data, m_data;

  dct_block_buffer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .init_n(init_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dct_start(dct_start), .dct_done(dct_done),
    .dct_rd_add(dct_rd_add), .dct_rd_data(dct_rd_data),
    .dct_wr_add(dct_wr_add), .dct_wr_n(dct_wr_n), .dct_wr_data(dct_wr_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
  } exp_t;

  // Reference model: what each memory should hold, plus the expected drain sequence.
  logic [IN_W-1:0]  pix  [DEPTH];
  logic [OUT_W-1:0] coef [DEPTH];
  exp_t             exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int xfers    = 0;
  int start_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_drain();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{coef[i], i == DEPTH - 1});
  endtask

  task automatic fill_block(input bit ramp);
    int  acc, guard;
    bit  hs;
    acc = 0;
    guard = 0;
    for (int i = 0; i < DEPTH; i++) pix[i] = ramp ? IN_W'(i) : IN_W'($urandom);
    tick();
    s_valid = 1'b1;
    s_data  = pix[0];
    while (acc < DEPTH && guard < 1000) begin
      @(negedge clk);
      hs = s_ready;
      tick();
      guard++;
      if (hs) begin
        acc++;
        s_data = (acc < DEPTH) ? pix[acc] : IN_W'($urandom);
      end
    end
    check("fill_accepts", acc, DEPTH);
    @(negedge clk);
    check("fill_s_ready_low", s_ready, 0);
    check("fill_start_high", dct_start, 1);
    check("fill_busy", busy, 1);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    check("start_one_cycle", dct_start, 0);
    check("run_busy", busy, 1);
  endtask

  task automatic check_read(input int a);
    tick();
    dct_rd_add = ADDR_W'(a);
    tick();
    @(negedge clk);
    check("rd_data", dct_rd_data, pix[a]);
  endtask

  task automatic drain(input bit toggle);
    int target, budget;
    target = xfers + DEPTH;
    budget = 0;
    while (xfers < target && budget < 2000) begin
      tick();
      m_ready = toggle ? !m_ready : 1'($urandom_range(1, 0));
      budget++;
    end
    check("drain_count", xfers, target);
    m_ready = 1'b0;
    @(negedge clk);
    check("post_drain_s_ready", s_ready, 1);
    check("post_drain_busy", busy, 0);
    check("post_drain_m_valid", m_valid, 0);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: compares every output transfer against the scoreboard and checks hold-during-stall.
  initial begin
    logic [OUT_W-1:0] pd;
    logic             pl;
    bit               ps;
    exp_t             e;
    ps = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (dct_start === 1'b1) start_cycles++;
      if (ps) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, pd);
        check("stall_last", m_last, pl);
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
        end
        xfers++;
      end
      ps = (m_valid === 1'b1) && (m_ready === 1'b0);
      pd = m_data;
      pl = m_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int ord[DEPTH];
    int j, tmp, a;
    logic [OUT_W-1:0] d;

    rst_n = 1'b0; init_n = 1'b1; s_valid = 1'b0; s_data = '0;
    dct_done = 1'b0; dct_rd_add = '0; dct_wr_add = '0; dct_wr_n = 1'b1;
    dct_wr_data = '0; m_ready = 1'b0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_dct_start", dct_start, 0);
    check("rst_rd_data", dct_rd_data, 0);
    check("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid_after", m_valid, 0);

    // Block 1: ramp pixels, addressed reads, scrambled writes with done on the last one.
    fill_block(1'b1);
    check("start_count_1", start_cycles, 1);
    tick();
    dct_rd_add = 6'd5;
    tick();
    dct_rd_add = 6'd63;
    @(negedge clk);
    check("rd_addr5", dct_rd_data, pix[5]);
    tick();
    @(negedge clk);
    check("rd_addr63", dct_rd_data, pix[63]);

    for (int i = 0; i < DEPTH; i++) ord[i] = i;
    for (int i = DEPTH - 2; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
    end
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      dct_wr_n    = 1'b0;
      dct_wr_add  = ADDR_W'(ord[k]);
      dct_wr_data = OUT_W'(12'hA00 + ord[k]);
      dct_done    = (k == DEPTH - 1);
      coef[ord[k]] = dct_wr_data;
    end
    push_drain();
    tick();
    dct_done    = 1'b0;
    dct_wr_add  = '0;
    dct_wr_data = 12'hFFF;
    tick();
    dct_wr_n = 1'b1;
    drain(1'b1);

    // Block 2: random pixels, partial writes, abandoned by a one-cycle soft clear.
    fill_block(1'b0);
    check("start_count_2", start_cycles, 2);
    for (int i = 0; i < 3; i++) check_read(int'($urandom_range(DEPTH - 1, 0)));
    for (int i = 0; i < 10; i++) begin
      tick();
      a = int'($urandom_range(DEPTH - 1, 0));
      d = OUT_W'($urandom);
      dct_wr_n = 1'b0; dct_wr_add = ADDR_W'(a); dct_wr_data = d;
      coef[a] = d;
    end
    tick();
    dct_wr_n = 1'b1;
    init_n   = 1'b0;
    tick();
    init_n = 1'b1;
    @(negedge clk);
    check("init_s_ready", s_ready, 1);
    check("init_busy", busy, 0);
    check("init_m_valid", m_valid, 0);
    check("init_dct_start", dct_start, 0);

    // Done and writes outside RUN must be ignored; they stay asserted through the next fill.
    tick();
    dct_done = 1'b1; dct_wr_n = 1'b0; dct_wr_add = 6'd1; dct_wr_data = 12'h123;
    tick();
    dct_done = 1'b0;
    @(negedge clk);
    check("done_in_fill_busy", busy, 0);
    check("done_in_fill_m_valid", m_valid, 0);
    check("start_count_after_init", start_cycles, 2);

    // Block 3: fresh fill, writes to addresses 2..63 only, done on its own cycle, random m_ready.
    fill_block(1'b0);
    dct_wr_n = 1'b1;
    check("start_count_3", start_cycles, 3);
    for (int i = 0; i < 3; i++) check_read(int'($urandom_range(DEPTH - 1, 0)));
    for (int i = 0; i < DEPTH - 2; i++) ord[i] = i + 2;
    for (int i = DEPTH - 3; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
    end
    for (int k = 0; k < DEPTH - 2; k++) begin
      tick();
      d = OUT_W'($urandom);
      dct_wr_n = 1'b0; dct_wr_add = ADDR_W'(ord[k]); dct_wr_data = d;
      coef[ord[k]] = d;
    end
    tick();
    dct_wr_n = 1'b1;
    dct_done = 1'b1;
    push_drain();
    tick();
    dct_done = 1'b0;
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
